// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler.
// State encodings, clock/baud constants and a modular add helper.
package uart_tx_sched_pkg;

   localparam int CLK_HZ  = 50_000_000;
   localparam int BIT_CYC = 5208;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_START   = 2'd1,
      S_WAIT_LO = 2'd2,
      S_GAP     = 2'd3
   } state_e;

   function automatic int wrap_add(input int a, input int b, input int n);
      int s;
      s = a + b;
      if (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Rotating-priority pick: first eligible requester at or after ptr.
// Pure combinational; the caller owns the pointer.
module rr_arbiter
   import uart_tx_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   input  logic [NREQ-1:0] mask,
   output logic            hit,
   output logic [IW-1:0]   idx
);

   logic [NREQ-1:0] elig;
   int              j;

   assign elig = req & mask;

   always_comb begin
      hit = 1'b0;
      idx = '0;
      j   = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = wrap_add(int'(ptr), k, NREQ);
         if (!hit && elig[j]) begin
            hit = 1'b1;
            idx = IW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one 8N1 UART transmitter between NREQ byte requesters with
// per-packet round-robin locking, inter-byte gap and lock timeout.
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int GAP_CYC = 0,
   parameter int LOCK_TO = 60000
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NREQ-1:0]           REQ,
   input  logic [NREQ-1:0]           LAST,
   input  logic [8*NREQ-1:0]         DATA,
   output logic [NREQ-1:0]           ACK,
   output logic                      TX_START,
   output logic [7:0]                TX_DATA,
   input  logic                      TX_BUSY,
   output logic                      GRANT_VLD,
   output logic [$clog2(NREQ)-1:0]   GRANT_ID,
   output logic                      LOCK_DROP,
   output logic                      IDLE
);

   localparam int IW = $clog2(NREQ);

   state_e          state_q, state_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic            start_q, start_d;
   logic [7:0]      txd_q, txd_d;
   logic [IW-1:0]   gid_q, gid_d;
   logic            lock_q, lock_d;
   logic            drop_q, drop_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [31:0]     gap_q, gap_d;
   logic [31:0]     to_q, to_d;

   logic [NREQ-1:0] mask;
   logic            hit;
   logic [IW-1:0]   win;

   function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] w);
      return (w == IW'(NREQ - 1)) ? '0 : w + 1'b1;
   endfunction

   // A locked packet leaves only its owner eligible.
   assign mask = lock_q ? (NREQ'(1) << gid_q) : '1;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req  (REQ),
      .ptr  (ptr_q),
      .mask (mask),
      .hit  (hit),
      .idx  (win)
   );

   always_comb begin
      state_d = state_q;
      ack_d   = '0;
      start_d = start_q;
      txd_d   = txd_q;
      gid_d   = gid_q;
      lock_d  = lock_q;
      drop_d  = 1'b0;
      ptr_d   = ptr_q;
      gap_d   = gap_q;
      to_d    = to_q;
      unique case (state_q)
         S_IDLE: begin
            if (hit && !TX_BUSY) begin
               state_d = S_START;
               ack_d   = NREQ'(1) << win;
               start_d = 1'b1;
               txd_d   = DATA[8*win +: 8];
               gid_d   = win;
               lock_d  = !LAST[win];
               to_d    = '0;
               if (LAST[win]) ptr_d = rr_next(win);
            end else if (LOCK_TO > 0 && lock_q && !REQ[gid_q]) begin
               if (to_q == 32'(LOCK_TO - 1)) begin
                  lock_d = 1'b0;
                  drop_d = 1'b1;
                  ptr_d  = rr_next(gid_q);
                  to_d   = '0;
               end else begin
                  to_d = to_q + 32'd1;
               end
            end
         end
         S_START: begin
            if (TX_BUSY) begin
               start_d = 1'b0;
               state_d = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            if (!TX_BUSY) begin
               if (GAP_CYC > 0) begin
                  state_d = S_GAP;
                  gap_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (gap_q == 32'(GAP_CYC - 1)) state_d = S_IDLE;
            else gap_d = gap_q + 32'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         ack_q   <= '0;
         start_q <= 1'b0;
         txd_q   <= '0;
         gid_q   <= '0;
         lock_q  <= 1'b0;
         drop_q  <= 1'b0;
         ptr_q   <= '0;
         gap_q   <= '0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         start_q <= start_d;
         txd_q   <= txd_d;
         gid_q   <= gid_d;
         lock_q  <= lock_d;
         drop_q  <= drop_d;
         ptr_q   <= ptr_d;
         gap_q   <= gap_d;
         to_q    <= to_d;
      end
   end

   assign ACK       = ack_q;
   assign TX_START  = start_q;
   assign TX_DATA   = txd_q;
   assign GRANT_ID  = gid_q;
   assign LOCK_DROP = drop_q;
   assign GRANT_VLD = lock_q | (state_q != S_IDLE);
   assign IDLE      = (state_q == S_IDLE) & ~lock_q & ~TX_BUSY;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: short-bit 8N1 transmitter model, transaction
// model of the scheduling rules, per-cycle compare and directed scenarios.
module tb_uart_tx_sched;

   localparam int N    = 4;
   localparam int GAP  = 10;
   localparam int LTO  = 100;
   localparam int BITC = 4;
   localparam int LIM  = 3000;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic [N-1:0]   REQ, LAST, ACK;
   logic [8*N-1:0] DATA;
   logic           TX_START, TX_BUSY, GRANT_VLD, LOCK_DROP, IDLE;
   logic [7:0]     TX_DATA;
   logic [1:0]     GRANT_ID;

   logic       req_b[N];
   logic       last_b[N];
   logic [7:0] dat_b[N];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   always_comb begin
      REQ  = '0;
      LAST = '0;
      DATA = '0;
      for (int i = 0; i < N; i++) begin
         REQ[i]          = req_b[i];
         LAST[i]         = last_b[i];
         DATA[8*i +: 8]  = dat_b[i];
      end
   end

   uart_tx_sched #(
      .NREQ    (N),
      .GAP_CYC (GAP),
      .LOCK_TO (LTO)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .REQ       (REQ),
      .LAST      (LAST),
      .DATA      (DATA),
      .ACK       (ACK),
      .TX_START  (TX_START),
      .TX_DATA   (TX_DATA),
      .TX_BUSY   (TX_BUSY),
      .GRANT_VLD (GRANT_VLD),
      .GRANT_ID  (GRANT_ID),
      .LOCK_DROP (LOCK_DROP),
      .IDLE      (IDLE)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   // Transmitter model: not reset by RST, like the real TX.
   logic       tx_busy = 1'b0;
   logic [9:0] tx_sh = '1;
   int         tx_cyc = 0;
   int         tx_bit = 0;
   logic       tx_line;

   assign TX_BUSY = tx_busy;
   assign tx_line = tx_busy ? tx_sh[0] : 1'b1;

   always @(posedge CLK) begin
      if (!tx_busy) begin
         if (TX_START === 1'b1) begin
            tx_sh   <= {1'b1, TX_DATA, 1'b0};
            tx_busy <= 1'b1;
            tx_cyc  <= 0;
            tx_bit  <= 0;
         end
      end else if (tx_cyc == BITC - 1) begin
         tx_cyc <= 0;
         tx_sh  <= {1'b1, tx_sh[9:1]};
         if (tx_bit == 9) tx_busy <= 1'b0;
         else tx_bit <= tx_bit + 1;
      end else begin
         tx_cyc <= tx_cyc + 1;
      end
   end

   // Scheduling model.
   bit         m_on = 0;
   bit         m_lock, m_infl, m_seen, m_start, m_drop;
   int         m_ptr, m_owner, m_to, m_gap, m_w, m_c;
   logic [3:0] m_ack;
   logic [7:0] m_data;
   int         glog[$];
   logic [7:0] expq[$];

   always @(posedge CLK) begin
      m_ack  = '0;
      m_drop = 0;
      if (RST) begin
         m_on = 1; m_ptr = 0; m_owner = 0; m_to = 0; m_gap = 0;
         m_lock = 0; m_infl = 0; m_seen = 0; m_start = 0; m_data = '0;
      end else if (m_on) begin
         if (!m_infl && m_gap == 0) begin
            m_w = -1;
            if (!TX_BUSY) begin
               for (int k = 0; k < N; k++) begin
                  m_c = (m_ptr + k) % N;
                  if (m_w < 0 && req_b[m_c] && (!m_lock || m_c == m_owner))
                     m_w = m_c;
               end
            end
            if (m_w >= 0) begin
               m_ack[m_w] = 1'b1;
               m_start = 1;
               m_data  = dat_b[m_w];
               m_owner = m_w;
               m_lock  = !last_b[m_w];
               if (last_b[m_w]) m_ptr = (m_w + 1) % N;
               m_to   = 0;
               m_infl = 1;
               m_seen = 0;
               glog.push_back(m_w);
               expq.push_back(dat_b[m_w]);
            end else if (m_lock && !req_b[m_owner]) begin
               m_to++;
               if (m_to == LTO) begin
                  m_lock = 0;
                  m_drop = 1;
                  m_ptr  = (m_owner + 1) % N;
                  m_to   = 0;
               end
            end
         end else if (m_infl && !m_seen) begin
            if (TX_BUSY) begin
               m_seen  = 1;
               m_start = 0;
            end
         end else if (m_infl) begin
            if (!TX_BUSY) begin
               m_infl = 0;
               m_gap  = GAP;
            end
         end else begin
            m_gap--;
         end
      end
   end

   always @(negedge CLK) begin
      if (m_on) begin
         chk("ack", 32'(ACK), 32'(m_ack));
         chk("tx_start", 32'(TX_START), 32'(m_start));
         chk("tx_data", 32'(TX_DATA), 32'(m_data));
         chk("grant_id", 32'(GRANT_ID), 32'(m_owner));
         chk("grant_vld", 32'(GRANT_VLD),
             32'(m_lock || m_infl || m_gap > 0));
         chk("lock_drop", 32'(LOCK_DROP), 32'(m_drop));
         chk("idle", 32'(IDLE),
             32'(!m_infl && m_gap == 0 && !m_lock && !TX_BUSY));
      end
   end

   // Line decoder: mid-bit sampling of each frame.
   int         frames = 0;
   logic [7:0] last_rx = '0;
   logic       sb, pb;
   logic [7:0] rx;

   always begin
      @(negedge tx_line);
      repeat (2) @(posedge CLK);
      #1 sb = tx_line;
      for (int i = 0; i < 8; i++) begin
         repeat (BITC) @(posedge CLK);
         #1 rx[i] = tx_line;
      end
      repeat (BITC) @(posedge CLK);
      #1 pb = tx_line;
      chk("frame_start_bit", 32'(sb), 32'd0);
      chk("frame_stop_bit", 32'(pb), 32'd1);
      if (expq.size() == 0) begin
         chk("frame_unexpected", 32'(rx), 32'hFFFF_FFFF);
      end else begin
         chk("frame_byte", 32'(rx), 32'(expq.pop_front()));
      end
      last_rx = rx;
      frames++;
   end

   task automatic send(input int i, input logic [7:0] d, input logic l);
      int c;
      req_b[i]  = 1'b1;
      dat_b[i]  = d;
      last_b[i] = l;
      c = 0;
      do begin
         @(negedge CLK);
         c++;
      end while (ACK[i] !== 1'b1 && c < LIM);
      chk($sformatf("ack_seen_req%0d", i), 32'(ACK[i]), 32'd1);
      req_b[i]  = 1'b0;
      last_b[i] = 1'b0;
   endtask

   task automatic wait_ack(input int i);
      int c;
      c = 0;
      do begin
         @(negedge CLK);
         c++;
      end while (ACK[i] !== 1'b1 && c < LIM);
      chk($sformatf("wait_ack%0d", i), 32'(ACK[i]), 32'd1);
   endtask

   task automatic wait_quiet();
      int c;
      c = 0;
      do begin
         @(negedge CLK);
         c++;
      end while ((TX_BUSY !== 1'b0 || GRANT_VLD !== 1'b0) && c < LIM);
      chk("quiet_reached", 32'(c < LIM), 32'd1);
   endtask

   task automatic wait_busy_fall(output int t);
      int c;
      c = 0;
      while (TX_BUSY !== 1'b1 && c < LIM) begin
         @(negedge CLK);
         c++;
      end
      while (TX_BUSY !== 1'b0 && c < LIM) begin
         @(negedge CLK);
         c++;
      end
      chk("busy_fall_seen", 32'(c < LIM), 32'd1);
      t = cyc;
   endtask

   task automatic do_reset();
      wait_quiet();
      glog.delete();
      RST = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      int tb, c;
      for (int i = 0; i < N; i++) begin
         req_b[i]  = 1'b0;
         last_b[i] = 1'b0;
         dat_b[i]  = '0;
      end
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      chk("rst_ack", 32'(ACK), 32'd0);
      chk("rst_tx_start", 32'(TX_START), 32'd0);
      chk("rst_grant_vld", 32'(GRANT_VLD), 32'd0);
      chk("rst_idle", 32'(IDLE), 32'd1);

      // single byte
      send(0, 8'hA5, 1'b1);
      wait_quiet();
      chk("t1_frames", 32'(frames), 32'd1);
      chk("t1_byte", 32'(last_rx), 32'hA5);
      chk("t1_idle", 32'(IDLE), 32'd1);

      // four requesters, round robin
      do_reset();
      fork
         begin
            send(0, 8'h11, 1'b1);
            send(0, 8'h55, 1'b1);
         end
         send(1, 8'h22, 1'b1);
         send(2, 8'h33, 1'b1);
         send(3, 8'h44, 1'b1);
      join
      wait_quiet();
      chk("t2_count", 32'(glog.size()), 32'd5);
      if (glog.size() == 5) begin
         chk("t2_g0", 32'(glog[0]), 32'd0);
         chk("t2_g1", 32'(glog[1]), 32'd1);
         chk("t2_g2", 32'(glog[2]), 32'd2);
         chk("t2_g3", 32'(glog[3]), 32'd3);
         chk("t2_g4", 32'(glog[4]), 32'd0);
      end

      // locked packet from requester 2
      do_reset();
      fork
         begin
            send(2, 8'hA1, 1'b0);
            send(2, 8'hA2, 1'b0);
            send(2, 8'hA3, 1'b1);
         end
         begin
            wait_ack(2);
            send(1, 8'hB1, 1'b1);
         end
      join
      wait_quiet();
      chk("t3_count", 32'(glog.size()), 32'd4);
      if (glog.size() == 4) begin
         chk("t3_g0", 32'(glog[0]), 32'd2);
         chk("t3_g2", 32'(glog[2]), 32'd2);
         chk("t3_g3", 32'(glog[3]), 32'd1);
      end

      // stalled lock released by timeout
      do_reset();
      send(3, 8'h5A, 1'b0);
      fork
         send(0, 8'h0F, 1'b1);
         begin
            wait_busy_fall(tb);
            c = 0;
            while (LOCK_DROP !== 1'b1 && c < LIM) begin
               @(negedge CLK);
               c++;
            end
            chk("t4_drop_delay", 32'(cyc - tb), 32'd111);
         end
      join
      wait_quiet();
      chk("t4_count", 32'(glog.size()), 32'd2);
      if (glog.size() == 2) chk("t4_g1", 32'(glog[1]), 32'd0);

      // inter-byte gap
      do_reset();
      send(1, 8'h81, 1'b1);
      fork
         send(1, 8'h7E, 1'b1);
         begin
            wait_busy_fall(tb);
            c = 0;
            while (TX_START !== 1'b1 && c < LIM) begin
               @(negedge CLK);
               c++;
            end
            chk("t5_gap_delay", 32'(cyc - tb), 32'd12);
         end
      join

      // reset while a byte is on the line
      do_reset();
      send(1, 8'h3C, 1'b1);
      c = 0;
      while (TX_BUSY !== 1'b1 && c < LIM) begin
         @(negedge CLK);
         c++;
      end
      repeat (8) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("t6_start_low", 32'(TX_START), 32'd0);
      chk("t6_no_ack", 32'(ACK), 32'd0);
      chk("t6_vld_low", 32'(GRANT_VLD), 32'd0);
      fork
         send(2, 8'hC3, 1'b1);
         begin
            wait_busy_fall(tb);
            c = 0;
            while (ACK[2] !== 1'b1 && c < LIM) begin
               @(negedge CLK);
               c++;
            end
            chk("t6_grant_delay", 32'(cyc - tb), 32'd1);
         end
      join
      wait_quiet();
      repeat (4) @(negedge CLK);
      chk("t6_last_byte", 32'(last_rx), 32'hC3);
      chk("total_frames", 32'(frames), 32'd16);
      chk("expq_empty", 32'(expq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
